// File: rtl/puf_ro_counter.sv
// puf_ro_counter: measures a pair of ring oscillators over a programmable window
// and turns the comparison of their edge counts into one PUF response bit.
//
// Optional build macro: PUF_RO_CNT_DIFF_EN adds o_diff = cnt_a - cnt_b (signed).
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                measurement request (only honoured in IDLE)
//   i_win_len[WIN_W]       count window in i_clk cycles (0 behaves as 1)
//   i_ro_a, i_ro_b         oscillator outputs, asynchronous to i_clk
//   o_en_a, o_en_b         oscillator enables
//   o_busy                 measurement in progress (start through DONE cycle)
//   o_done                 one-cycle pulse, results valid
//   o_resp, o_tie          cnt_a > cnt_b, cnt_a == cnt_b
//   o_cnt_a, o_cnt_b       final edge counts, held until the next start
//   o_diff[CNT_W+1]        (PUF_RO_CNT_DIFF_EN only) cnt_a - cnt_b
module puf_ro_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_ro_a,
  input  logic             i_ro_b,
  output logic             o_en_a,
  output logic             o_en_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_resp,
  output logic             o_tie,
`ifdef PUF_RO_CNT_DIFF_EN
  output logic [CNT_W:0]   o_diff,
`endif
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic                   prev_a_q, prev_b_q;
  logic [CNT_W-1:0]       cnt_a_q, cnt_b_q;
  logic [CNT_W-1:0]       cnt_a_d, cnt_b_d;
  logic [WIN_W-1:0]       win_q, win_cnt_q, win_d;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic                   en_q, busy_q, done_q, resp_q, tie_q;
  logic [CNT_W-1:0]       res_a_q, res_b_q;
  logic                   rise_a, rise_b, win_last;
`ifdef PUF_RO_CNT_DIFF_EN
  logic [CNT_W:0]         diff_q;
`endif

  // Synchronisers and previous-value registers for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], i_ro_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], i_ro_b};
      prev_a_q <= sync_a_q[SYNC_STAGES-1];
      prev_b_q <= sync_b_q[SYNC_STAGES-1];
    end
  end

  // Edge detect, saturating increments, effective window and last-window-cycle flag
  always_comb begin
    rise_a   = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
    rise_b   = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;
    cnt_a_d  = (rise_a && (cnt_a_q != '1)) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
    cnt_b_d  = (rise_b && (cnt_b_q != '1)) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
    win_d    = (i_win_len == '0) ? WIN_W'(1) : i_win_len;
    win_last = (win_cnt_q == win_q - WIN_W'(1));
  end

  // Measurement FSM. COUNT spends W cycles counting with the enables up, then one
  // drain cycle with the enables down so the last counted edge has settled into
  // the counters before the results are captured on entry to DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      win_q     <= '0;
      win_cnt_q <= '0;
      arm_cnt_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= 1'b0;
      tie_q     <= 1'b0;
      res_a_q   <= '0;
      res_b_q   <= '0;
`ifdef PUF_RO_CNT_DIFF_EN
      diff_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= ST_ARM;
            win_q     <= win_d;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            arm_cnt_q <= '0;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            res_a_q   <= '0;
            res_b_q   <= '0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
`ifdef PUF_RO_CNT_DIFF_EN
            diff_q    <= '0;
`endif
          end
        end
        ST_ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_q   <= ST_COUNT;
            win_cnt_q <= '0;
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        ST_COUNT: begin
          if (en_q) begin
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            if (win_last) en_q <= 1'b0;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            res_a_q <= cnt_a_q;
            res_b_q <= cnt_b_q;
            resp_q  <= (cnt_a_q > cnt_b_q);
            tie_q   <= (cnt_a_q == cnt_b_q);
`ifdef PUF_RO_CNT_DIFF_EN
            diff_q  <= {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_en_a  = en_q;
  assign o_en_b  = en_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_resp  = resp_q;
  assign o_tie   = tie_q;
  assign o_cnt_a = res_a_q;
  assign o_cnt_b = res_b_q;
`ifdef PUF_RO_CNT_DIFF_EN
  assign o_diff  = diff_q;
`endif

endmodule
